// File: rtl/sap_control_sequencer.sv
// T-state control sequencer for the 8-bit CPU: a six-step fetch/execute machine
// whose outputs are a combinational decode of the current step, opcode and carry.
module sap_control_sequencer #(
  parameter int OPCODE_W    = 4,
  parameter bit SHORT_CYCLE = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_step_en,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_alu_cf,
  output logic                o_pc_clr_n,
  output logic                o_pc_cp,
  output logic                o_pc_ep,
  output logic                o_pc_lp,
  output logic                o_mar_lm,
  output logic                o_ram_ce,
  output logic                o_ir_li,
  output logic                o_ir_ei,
  output logic                o_a_la,
  output logic                o_a_ea,
  output logic                o_b_lb,
  output logic                o_alu_su,
  output logic                o_alu_eu,
  output logic                o_out_lo,
  output logic                o_halted,
  output logic [2:0]          o_t_state
);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'h0);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'h1);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'h2);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'h3);
  localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(4'h4);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'hE);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'hF);

  state_t r_state;
  state_t w_state_step;
  state_t w_state_next;

  logic w_is_lda, w_is_add, w_is_sub, w_is_jmp, w_is_jc, w_is_out, w_is_hlt;
  logic w_is_arith;
  logic w_cp, w_lp, w_lm, w_li, w_la, w_lb, w_lo;

  assign w_is_lda   = (i_opcode == OP_LDA);
  assign w_is_add   = (i_opcode == OP_ADD);
  assign w_is_sub   = (i_opcode == OP_SUB);
  assign w_is_jmp   = (i_opcode == OP_JMP);
  assign w_is_jc    = (i_opcode == OP_JC);
  assign w_is_out   = (i_opcode == OP_OUT);
  assign w_is_hlt   = (i_opcode == OP_HLT);
  assign w_is_arith = w_is_add | w_is_sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_step = r_state;
    o_pc_clr_n   = 1'b1;
    o_pc_ep      = 1'b0;
    o_ram_ce     = 1'b0;
    o_ir_ei      = 1'b0;
    o_a_ea       = 1'b0;
    o_alu_eu     = 1'b0;
    o_alu_su     = 1'b0;
    o_halted     = 1'b0;
    w_cp         = 1'b0;
    w_lp         = 1'b0;
    w_lm         = 1'b0;
    w_li         = 1'b0;
    w_la         = 1'b0;
    w_lb         = 1'b0;
    w_lo         = 1'b0;
    case (r_state)
      S_INIT: begin
        o_pc_clr_n   = 1'b0;
        w_state_step = S_T1;
      end
      S_T1: begin
        o_pc_ep      = 1'b1;
        w_lm         = 1'b1;
        w_state_step = S_T2;
      end
      S_T2: begin
        w_cp         = 1'b1;
        w_state_step = S_T3;
      end
      S_T3: begin
        o_ram_ce     = 1'b1;
        w_li         = 1'b1;
        w_state_step = S_T4;
      end
      S_T4: begin
        w_state_step = S_T5;
        if (w_is_lda || w_is_arith) begin
          o_ir_ei = 1'b1;
          w_lm    = 1'b1;
        end else if (w_is_hlt) begin
          w_state_step = S_HALT;
        end else begin
          if (w_is_jmp || w_is_jc) begin
            o_ir_ei = 1'b1;
            w_lp    = w_is_jmp | i_alu_cf;
          end else if (w_is_out) begin
            o_a_ea = 1'b1;
            w_lo   = 1'b1;
          end
          // JMP, JC, OUT and NOP have nothing left to do after T4.
          if (SHORT_CYCLE) w_state_step = S_T1;
        end
      end
      S_T5: begin
        w_state_step = S_T6;
        if (w_is_lda) begin
          o_ram_ce = 1'b1;
          w_la     = 1'b1;
          if (SHORT_CYCLE) w_state_step = S_T1;
        end else if (w_is_arith) begin
          o_ram_ce = 1'b1;
          w_lb     = 1'b1;
        end
      end
      S_T6: begin
        w_state_step = S_T1;
        if (w_is_arith) begin
          o_alu_eu = 1'b1;
          w_la     = 1'b1;
          o_alu_su = w_is_sub;
        end
      end
      S_HALT: begin
        o_halted     = 1'b1;
        w_state_step = S_HALT;
      end
      default: w_state_step = S_INIT;
    endcase
    w_state_next = i_step_en ? w_state_step : r_state;
  end

  // Load/count strobes only fire on cycles that actually advance the machine.
  assign o_pc_cp   = w_cp & i_step_en;
  assign o_pc_lp   = w_lp & i_step_en;
  assign o_mar_lm  = w_lm & i_step_en;
  assign o_ir_li   = w_li & i_step_en;
  assign o_a_la    = w_la & i_step_en;
  assign o_b_lb    = w_lb & i_step_en;
  assign o_out_lo  = w_lo & i_step_en;
  assign o_t_state = r_state;

endmodule
